// File: rtl/grant_arbiter_pkg.sv
// rtl/grant_arbiter_pkg.sv - shared types and sizes for the grant arbiter
package grant_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/grant_arbiter_decoder.sv
// rtl/grant_arbiter_decoder.sv - 3-to-8 one-hot decoder
module decoder
  import grant_arbiter_pkg::*;
(
  input  logic [IDX_W-1:0]   sel,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/grant_arbiter.sv
// rtl/grant_arbiter.sv - 8-way round-robin arbiter with hold limit and one-cycle gap
module grant_arbiter
  import grant_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout,
  output logic               busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;

  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] dec_out;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    winner = ptr_q;
    cand   = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr_q + IDX_W'(k);
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (|req) begin
          state_d = BUSY;
          idx_d   = winner;
          valid_d = 1'b1;
          ptr_d   = winner + IDX_W'(1);
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // A release on the final hold cycle is treated as a plain release.
        if (!req[idx_q] || (hold_q == HOLD_LAST)) begin
          state_d   = GAP;
          idx_d     = '0;
          valid_d   = 1'b0;
          hold_d    = '0;
          timeout_d = req[idx_q];
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  decoder u_decoder (
    .sel    (idx_q),
    .onehot (dec_out)
  );

  assign grant       = dec_out & {NUM_REQ{valid_q}};
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_grant_arbiter.sv
// tb/tb_grant_arbiter.sv - self-checking bench for grant_arbiter
module tb_grant_arbiter;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  grant_arbiter #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    step();
    step();
    n_checks++; if (grant !== 8'h00) begin n_err++; $display("FAIL reset_grant got=%h exp=00", grant); end
    n_checks++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", grant_valid); end
    n_checks++; if (grant_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx got=%0d exp=0", grant_idx); end
    n_checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_flags got to=%b busy=%b exp=0,0", timeout, busy); end
    req   = 8'h00;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    req = 8'b0000_0100;
    step();
    n_checks++; if (grant !== 8'h04 || grant_idx !== 3'd2 || busy !== 1'b1 || grant_valid !== 1'b1)
      begin n_err++; $display("FAIL single_grant got=%h/%0d/%b/%b exp=04/2/1/1", grant, grant_idx, busy, grant_valid); end
    req = 8'h00;
    step();
    n_checks++; if (grant !== 8'h00 || busy !== 1'b1 || timeout !== 1'b0)
      begin n_err++; $display("FAIL single_gap got=%h busy=%b to=%b exp=00,1,0", grant, busy, timeout); end
    step();
    n_checks++; if (busy !== 1'b0 || grant !== 8'h00)
      begin n_err++; $display("FAIL single_idle got busy=%b grant=%h exp=0,00", busy, grant); end
  endtask

  task automatic test_wrap();
    req = 8'b1000_0001;
    step();
    n_checks++; if (grant_idx !== 3'd7 || grant !== 8'h80)
      begin n_err++; $display("FAIL wrap_first got=%0d/%h exp=7/80", grant_idx, grant); end
    req = 8'b0000_0001;
    step();
    n_checks++; if (grant !== 8'h00 || timeout !== 1'b0)
      begin n_err++; $display("FAIL wrap_gap got=%h to=%b exp=00,0", grant, timeout); end
    step();
    n_checks++; if (grant_idx !== 3'd0 || grant !== 8'h01)
      begin n_err++; $display("FAIL wrap_second got=%0d/%h exp=0/01", grant_idx, grant); end
    req = 8'h00;
    step();
    step();
  endtask

  task automatic test_rotate();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < MH; c++) begin
        step();
        n_checks++; if (grant_idx !== 3'(g % 8) || grant !== (8'h01 << (g % 8)) || timeout !== 1'b0)
          begin n_err++; $display("FAIL rotate_hold g=%0d c=%0d got=%0d/%h/%b exp=%0d", g, c, grant_idx, grant, timeout, g % 8); end
      end
      step();
      n_checks++; if (grant !== 8'h00 || timeout !== 1'b1 || busy !== 1'b1)
        begin n_err++; $display("FAIL rotate_gap g=%0d got=%h to=%b busy=%b exp=00,1,1", g, grant, timeout, busy); end
    end
    req = 8'h00;
    step();
    step();
  endtask

  task automatic test_coincide();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 8'b0010_0000;
    for (int c = 0; c < MH; c++) step();
    n_checks++; if (grant_idx !== 3'd5 || grant_valid !== 1'b1)
      begin n_err++; $display("FAIL coincide_owner got=%0d/%b exp=5/1", grant_idx, grant_valid); end
    req = 8'h00;
    step();
    n_checks++; if (grant !== 8'h00 || timeout !== 1'b0 || busy !== 1'b1)
      begin n_err++; $display("FAIL coincide_gap got=%h to=%b busy=%b exp=00,0,1", grant, timeout, busy); end
    step();
  endtask

  task automatic test_reset_mid_busy();
    req = 8'h40;
    step();
    step();
    n_checks++; if (grant_idx !== 3'd6 || grant !== 8'h40)
      begin n_err++; $display("FAIL midrst_owner got=%0d/%h exp=6/40", grant_idx, grant); end
    rst_n = 1'b0;
    step();
    n_checks++; if (grant !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0 || grant_valid !== 1'b0)
      begin n_err++; $display("FAIL midrst_drop got=%h busy=%b to=%b v=%b exp=00,0,0,0", grant, busy, timeout, grant_valid); end
    rst_n = 1'b1;
    req   = 8'hC0;
    step();
    n_checks++; if (grant_idx !== 3'd6 || grant !== 8'h40)
      begin n_err++; $display("FAIL midrst_regrant got=%0d/%h exp=6/40", grant_idx, grant); end
    req = 8'h00;
    step();
    step();
  endtask

  task automatic test_random();
    int       m_owner;
    int       m_hold;
    int       m_ptr;
    bit       m_gap;
    bit       m_to;
    int       run_len;
    int       waits[8];
    bit       prev_valid;
    logic [7:0] exp_grant;
    logic [7:0] req_at_edge;
    logic       rst_at_edge;

    rst_n = 1'b0;
    req   = 8'h00;
    step();
    rst_n = 1'b1;
    m_owner = -1; m_hold = 0; m_ptr = 0; m_gap = 0; m_to = 0;
    run_len = 0; prev_valid = 0;
    foreach (waits[i]) waits[i] = 0;

    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(7, 0) == 0) req[b] = ~req[b];
      rst_n = ($urandom_range(499, 0) != 0);
      req_at_edge = req;
      rst_at_edge = rst_n;
      @(posedge clk);
      // Reference: owner/ptr as integers, advancing by the arbitration rules.
      if (!rst_at_edge) begin
        m_owner = -1; m_hold = 0; m_ptr = 0; m_gap = 0; m_to = 0;
      end else if (m_owner < 0) begin
        m_to = 0;
        m_gap = 0;
        if (req_at_edge != 8'h00) begin
          for (int k = 7; k >= 0; k--)
            if (req_at_edge[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
          m_ptr  = (m_owner + 1) % 8;
          m_hold = 1;
        end
      end else begin
        if (!req_at_edge[m_owner]) begin
          m_owner = -1; m_gap = 1; m_to = 0;
        end else if (m_hold == MH) begin
          m_owner = -1; m_gap = 1; m_to = 1;
        end else begin
          m_hold++;
        end
      end
      #1;
      exp_grant = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      n_checks++; if (grant !== exp_grant || grant_valid !== (m_owner >= 0))
        begin n_err++; $display("FAIL rand_grant cyc=%0d got=%h/%b exp=%h", cyc, grant, grant_valid, exp_grant); end
      n_checks++; if (grant_idx !== ((m_owner >= 0) ? 3'(m_owner) : 3'd0))
        begin n_err++; $display("FAIL rand_idx cyc=%0d got=%0d exp=%0d", cyc, grant_idx, m_owner); end
      n_checks++; if (timeout !== m_to || busy !== ((m_owner >= 0) || m_gap))
        begin n_err++; $display("FAIL rand_flags cyc=%0d got to=%b busy=%b exp to=%b", cyc, timeout, busy, m_to); end
      n_checks++; if (!$onehot0(grant) || grant_valid !== (|grant))
        begin n_err++; $display("FAIL rand_onehot cyc=%0d got=%h v=%b", cyc, grant, grant_valid); end
      run_len = grant_valid ? run_len + 1 : 0;
      n_checks++; if (run_len > MH)
        begin n_err++; $display("FAIL rand_hold cyc=%0d got=%0d max=%0d", cyc, run_len, MH); end
      if (grant_valid && !prev_valid) begin
        for (int i = 0; i < 8; i++) begin
          if (!req_at_edge[i] || i == int'(grant_idx)) waits[i] = 0;
          else waits[i]++;
          n_checks++; if (waits[i] > 7)
            begin n_err++; $display("FAIL rand_starve cyc=%0d req=%0d got=%0d max=7", cyc, i, waits[i]); end
        end
      end
      if (!rst_n) foreach (waits[i]) waits[i] = 0;
      prev_valid = grant_valid;
    end
    rst_n = 1'b1;
    req   = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    test_reset();
    test_single();
    test_wrap();
    test_rotate();
    test_coincide();
    test_reset_mid_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/grant_arbiter.md
GRANT_ARBITER -- requirements
Module: grant_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 16, max consecutive grant cycles per owner before forced revoke; legal range 2..256.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  8  request lines; bit i = requester i.
REQ-005 grant  output  8  one-hot grant; all-zero when no owner.
REQ-006 grant_idx  output  3  index of current owner; 0 when grant_valid low.
REQ-007 grant_valid  output  1  high while an owner holds the grant.
REQ-008 timeout  output  1  one-cycle pulse when a grant is forcibly revoked.
REQ-009 busy  output  1  high in BUSY and GAP states.

Function
REQ-010 FSM states SHALL be IDLE, BUSY, GAP; all outputs registered.
REQ-011 Round-robin pointer ptr (3 bits) SHALL select winner = first i with req[i]=1 scanning ptr, ptr+1, ... ptr+7 mod 8.
REQ-012 IDLE or GAP with any req bit high at edge SHALL move to BUSY: grant_valid=1, grant_idx=winner, grant=one-hot(winner), ptr=winner+1 mod 8, hold counter=0.
REQ-013 IDLE with req=0 SHALL stay IDLE; GAP with req=0 SHALL go to IDLE.
REQ-014 Request-to-grant latency SHALL be exactly one cycle from IDLE or GAP.
REQ-015 In BUSY, hold counter SHALL increment each cycle the grant is retained; width ceil(log2(MAX_HOLD)).
REQ-016 BUSY SHALL exit to GAP when req[grant_idx]=0 (release) or hold counter = MAX_HOLD-1 (timeout); grant, grant_idx, grant_valid clear on that edge.
REQ-017 Grant SHALL be held for at most MAX_HOLD cycles; timeout SHALL pulse high for exactly the first GAP cycle only on timeout exit.
REQ-018 If release and timeout coincide, release SHALL win: no timeout pulse.
REQ-019 Changes on non-owner req bits during BUSY SHALL be ignored.
REQ-020 GAP SHALL last exactly one cycle with grant=0; back-to-back owners are separated by one idle grant cycle.
REQ-021 A requester re-asserting in GAP SHALL only win if no other requester precedes it from ptr (no starvation: each active requester served within 7 other grants).
REQ-022 grant SHALL never have more than one bit set; grant_valid SHALL equal |grant.

Reset
REQ-023 rst_n low at edge SHALL force state IDLE, ptr=0, hold counter=0, grant=0, grant_idx=0, grant_valid=0, timeout=0, busy=0.
REQ-024 Reset asserted mid-BUSY SHALL drop grant on that same edge with no timeout pulse; first arbitration after reset starts from ptr=0.
REQ-025 req SHALL be ignored while rst_n low.

Structure
REQ-026 Shared package SHALL hold state enum (IDLE, BUSY, GAP), NUM_REQ=8, IDX_W=3.
REQ-027 grant SHALL be produced by instantiating the team's existing 3-to-8 decoder sub-module (decoder) on grant_idx, gated with grant_valid.
REQ-028 Winner selection SHALL be combinational priority-rotate logic; no other sub-modules.

Verification
REQ-029 Reset, then req=8'b0000_0100 held -> one cycle later grant=8'h04, grant_idx=2, busy=1; drop req[2] -> next edge grant=0, then IDLE.
REQ-030 req=8'hFF held continuously, MAX_HOLD=4 -> grants rotate idx 0,1,2..7,0, each exactly 4 cycles, timeout pulse after each, one GAP cycle between.
REQ-031 ptr=3 (after serving idx 2), req=8'b1000_0001 -> winner idx 7, then idx 0.
REQ-032 Owner idx 5 releases on same cycle counter hits MAX_HOLD-1 -> GAP with timeout=0.
REQ-033 rst_n low mid-BUSY (owner idx 6) -> grant=0, state IDLE next edge; req=8'h40 afterwards -> regranted idx 6 from ptr=0 scan.
REQ-034 Random req for 10k cycles -> assert grant one-hot-or-zero, hold ≤ MAX_HOLD, no requester waits more than 7 grants.
